sevenseg_mux_n: RTL

- Parametrised N-digit time-multiplexed seven-segment display driver; generalises the two-display hex mux to any digit count.
- Adds anode dead-time blanking, per-digit enable (leading-zero suppression), tear-free shadow loading on frame boundaries and a frame strobe.
- Sits between the lab top level (switch/sum logic) and the FPGA pins; one instance drives the whole display bank.

---
 rtl/sevenseg_pkg.sv | 24 ++
 rtl/sevenseg_decoder.sv | 12 +
 rtl/sevenseg_mux_n.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}, so bit SEG_A is the LSB.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs for hex digits 0-F.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex to active-high seven-segment decoder.
// Pin polarity is applied by the instantiating driver, not here.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_PATTERNS[hex_i];

endmodule

// File: rtl/sevenseg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with dead-time blanking,
// per-digit enables and frame-aligned shadow loading. Macro SEVENSEG_DP_EN adds a decimal point.
module sevenseg_mux_n
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 4096,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
`ifdef SEVENSEG_DP_EN
   ,input  logic [NUM_DIGITS-1:0]     dp,
    output logic                      seg_dp
`endif
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  POL        = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF    = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{POL}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              frame_end;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        frame_end = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d   = BLANK;
                    cnt_d     = '0;
                    frame_end = (idx_q == IDX_LAST);
                    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // load is a fire-and-forget request: any cycle with load=1 arms one pending flag, and
    // the values on digits/digit_en during the frame_done cycle are what get captured.
    logic [4*NUM_DIGITS-1:0] shadow_digits_q;
    logic [NUM_DIGITS-1:0]   shadow_en_q;
    logic                    pending_q;
    logic                    frame_done_q;
    logic                    capture;

    assign capture = frame_done_q && (pending_q || load);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_digits_q <= '0;
            shadow_en_q     <= '0;
            pending_q       <= 1'b0;
        end else if (capture) begin
            shadow_digits_q <= digits;
            shadow_en_q     <= digit_en;
            pending_q       <= 1'b0;
        end else if (load) begin
            pending_q       <= 1'b1;
        end
    end

    logic [3:0]            cur_digit;
    logic                  cur_en;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            seg_hi;
    logic                  lit;

    always_comb begin
        cur_digit = '0;
        cur_en    = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit    = shadow_digits_q[4*i +: 4];
                cur_en       = shadow_en_q[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    sevenseg_decoder u_decoder (
        .hex_i (cur_digit),
        .seg_o (seg_hi)
    );

    assign lit = (state_q == SHOW) && cur_en;

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= lit ? (seg_hi ^ SEG_OFF) : SEG_OFF;
            an_q         <= lit ? (an_onehot ^ AN_OFF) : AN_OFF;
            frame_done_q <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

`ifdef SEVENSEG_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp_q;
    logic                  cur_dp;
    logic                  seg_dp_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_dp_q <= '0;
        end else if (capture) begin
            shadow_dp_q <= dp;
        end
    end

    always_comb begin
        cur_dp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dp = shadow_dp_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_dp_q <= POL;
        end else begin
            seg_dp_q <= (lit && cur_dp) ? ~POL : POL;
        end
    end

    assign seg_dp = seg_dp_q;
`else
    // Without the decimal point there is no dp shadow or output register.
`endif

endmodule
